bus_scanner: RTL and testbench
==============================

BUS_SCANNER -- requirements
Module: bus_scanner

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 div  input  4  dwell setting; latched at start; settle time per channel = div+1 cycles.
REQ-006 mux_out  input  4  selected nibble returned by the downstream 8:1 4-bit bus mux.
REQ-007 sel  output  3  channel select driven to the mux sel input.
REQ-008 busy  output  1  high while a scan is in progress.
REQ-009 done  output  1  single-cycle pulse at scan completion.
REQ-010 snapshot  output  32  captured channels; bits [4i+3:4i] = value read with sel=i.
REQ-011 max_val  output  4  largest captured value of the last scan.
REQ-012 max_idx  output  3  channel index of max_val.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE, start=1 SHALL produce: sel<=0, cnt<=div, div latched, max_val<=0, max_idx<=0, next state SETTLE.
REQ-015 IDLE, start=0 SHALL hold all outputs.
REQ-016 SETTLE, cnt!=0 SHALL decrement cnt and stay in SETTLE; cnt==0 SHALL go to SAMPLE.
REQ-017 SAMPLE SHALL write mux_out into snapshot nibble [sel] and leave all other nibbles unchanged.
REQ-018 SAMPLE at sel=0 SHALL load max_val<=mux_out and max_idx<=0 unconditionally.
REQ-019 SAMPLE at sel>0 SHALL update max_val/max_idx only when mux_out > max_val (strictly greater); on ties the lower index is kept.
REQ-020 SAMPLE, sel!=7: sel<=sel+1, cnt<=latched div, next state SETTLE.
REQ-021 SAMPLE, sel==7: sel stays 7, next state DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-023 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-024 Each channel SHALL take div+2 cycles; DONE SHALL be entered 8*(div+2) edges after the start edge.
REQ-025 start asserted outside IDLE SHALL be ignored, including in the DONE cycle.
REQ-026 snapshot, max_val and max_idx SHALL hold after DONE until the corresponding SAMPLE writes of the next scan.
REQ-027 sel SHALL not change during SETTLE, so mux_out has div+1 stable cycles before capture.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE with sel=0, cnt=0, busy=0, done=0, snapshot=0, max_val=0, max_idx=0.
REQ-029 reset SHALL override start and any in-progress scan; no partial done pulse.

Verification
REQ-030 Mux inputs 12,15,1,3,5,2,11,14 on channels 0..7, div=0, start pulse -> done 16 cycles after the start edge; snapshot=32'hEB2531FC, max_val=15, max_idx=1.
REQ-031 Same data with div=15 -> done 136 cycles after the start edge; sel dwells 17 cycles per channel; busy high for 136 cycles.
REQ-032 All channels = 7 -> max_val=7, max_idx=0 (tie keeps lowest index).
REQ-033 start re-pulsed mid-scan and during the DONE cycle -> no restart; exactly one done pulse at the REQ-024 time.
REQ-034 reset asserted at sel=4 mid-scan -> next cycle IDLE with sel=0, snapshot=0, busy=0; no done pulse; a new start performs a full correct scan.
REQ-035 Two back-to-back scans with channel 3 changed from 3 to 9 between scans -> second snapshot=32'hEB2591FC, max_idx=1; first-scan values hold until overwritten.

Source files
------------

// File: rtl/bus_scanner_if.sv
// Bus between the scanner, its requester and the downstream 8:1 nibble mux.
// slave = scanner side; master = requester/mux side.
interface bus_scanner_if;
    logic        start;
    logic [3:0]  div;
    logic [3:0]  mux_out;
    logic [2:0]  sel;
    logic        busy;
    logic        done;
    logic [31:0] snapshot;
    logic [3:0]  max_val;
    logic [2:0]  max_idx;

    modport slave (
        input  start, div, mux_out,
        output sel, busy, done, snapshot, max_val, max_idx
    );

    modport master (
        output start, div, mux_out,
        input  sel, busy, done, snapshot, max_val, max_idx
    );
endinterface

// File: rtl/bus_scanner.sv
// Steps sel across an 8:1 nibble mux, dwelling div+1 cycles per channel before capture.
// A full scan takes 8*(div+2) cycles; start is ignored outside IDLE.
module bus_scanner (
    input  logic          clk,
    input  logic          reset,
    bus_scanner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t      state_q;
    logic [2:0]  sel_q;
    logic [3:0]  cnt_q;
    logic [3:0]  div_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] snapshot_q;
    logic [3:0]  max_val_q;
    logic [2:0]  max_idx_q;
    logic        take_max_d;

    // Channel 0 seeds the running maximum; later channels must be strictly larger.
    always_comb begin
        take_max_d = (sel_q == 3'd0) || (bus.mux_out > max_val_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 3'd0;
            cnt_q      <= 4'd0;
            div_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            snapshot_q <= 32'd0;
            max_val_q  <= 4'd0;
            max_idx_q  <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sel_q     <= 3'd0;
                        cnt_q     <= bus.div;
                        div_q     <= bus.div;
                        max_val_q <= 4'd0;
                        max_idx_q <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    snapshot_q[{sel_q, 2'b00} +: 4] <= bus.mux_out;
                    if (take_max_d) begin
                        max_val_q <= bus.mux_out;
                        max_idx_q <= sel_q;
                    end
                    if (sel_q != 3'd7) begin
                        sel_q   <= sel_q + 3'd1;
                        cnt_q   <= div_q;
                        state_q <= SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.snapshot = snapshot_q;
    assign bus.max_val  = max_val_q;
    assign bus.max_idx  = max_idx_q;
endmodule

// File: tb/tb_bus_scanner.sv
// Randomised and directed scans of bus_scanner; a monitor checks each done pulse
// against expectations queued by the driver when the scan was started.
module tb_bus_scanner;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [3:0] ch [8];

    bus_scanner_if bus();
    bus_scanner dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mux_out = ch[bus.sel];

    typedef struct {
        logic [31:0] snap;
        logic [3:0]  mv;
        logic [2:0]  mi;
        int          done_edge;
        int          dwell;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: snapshot is the channels laid side by side; max index is the first
    // position holding the overall maximum.
    function automatic exp_t model(input int d, input int start_edge);
        exp_t e;
        int   mx;
        e.snap = 32'd0;
        mx = 0;
        for (int i = 0; i < 8; i++) begin
            e.snap = e.snap | (32'(ch[i]) << (4 * i));
            if (int'(ch[i]) > mx) mx = int'(ch[i]);
        end
        e.mv = 4'(mx);
        e.mi = 3'd0;
        for (int i = 7; i >= 0; i--) if (int'(ch[i]) == mx) e.mi = 3'(i);
        e.dwell = d + 2;
        e.done_edge = start_edge + 8 * (d + 2);
        return e;
    endfunction

    // Monitor
    int sel_cnt [8];
    int busy_cnt;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int i = 0; i < 8; i++) sel_cnt[i] = 0;
            busy_cnt = 0;
        end else begin
            if (bus.busy) begin
                sel_cnt[bus.sel]++;
                busy_cnt++;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_done");
                end else begin
                    e = exp_q.pop_front();
                    chk("snapshot", bus.snapshot, e.snap);
                    chk("max_val", 32'(bus.max_val), 32'(e.mv));
                    chk("max_idx", 32'(bus.max_idx), 32'(e.mi));
                    chk("done_edge", cyc, e.done_edge);
                    chk("busy_cycles", busy_cnt, 8 * e.dwell);
                    for (int i = 0; i < 8; i++) chk("sel_dwell", sel_cnt[i], e.dwell);
                end
                for (int i = 0; i < 8; i++) sel_cnt[i] = 0;
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!bus.busy && !bus.done) return;
            @(negedge clk);
        end
        fail_now("wait_idle");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        fail_now("wait_done");
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_scan(input int d);
        wait_idle();
        bus.div   = 4'(d);
        bus.start = 1'b1;
        exp_q.push_back(model(d, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic set_ch(input logic [31:0] packed_ch);
        logic [31:0] p;
        p = packed_ch;
        for (int i = 0; i < 8; i++) ch[i] = p[4*i +: 4];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.div   = 4'd0;
        set_ch(32'h0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_snapshot", bus.snapshot, 0);
        chk("rst_max_val", 32'(bus.max_val), 0);
        chk("rst_max_idx", 32'(bus.max_idx), 0);

        // Reference data set, fastest dwell
        set_ch(32'hEB2531FC);
        start_scan(0);
        wait_done();
        chk("d0_snapshot", bus.snapshot, 32'hEB2531FC);
        chk("d0_max_val", 32'(bus.max_val), 15);
        chk("d0_max_idx", 32'(bus.max_idx), 1);

        // Slowest dwell
        start_scan(15);
        wait_done();
        chk("d15_snapshot", bus.snapshot, 32'hEB2531FC);

        // Back-to-back with channel 3 changed; old snapshot must survive until overwritten
        prev = bus.snapshot;
        ch[3] = 4'd9;
        start_scan(0);
        chk("hold_snapshot", bus.snapshot, prev);
        wait_done();
        chk("b2b_snapshot", bus.snapshot, 32'hEB2591FC);
        chk("b2b_max_idx", 32'(bus.max_idx), 1);

        // All channels equal: tie keeps lowest index
        set_ch(32'h77777777);
        start_scan($urandom_range(0, 5));
        wait_done();
        chk("tie_max_val", 32'(bus.max_val), 7);
        chk("tie_max_idx", 32'(bus.max_idx), 0);

        // start re-pulsed mid-scan and during the DONE cycle
        set_ch($urandom);
        start_scan(2);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("no_restart_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("no_restart_busy2", 32'(bus.busy), 0);
        chk("no_restart_done", 32'(bus.done), 0);

        // Reset mid-scan at sel=4
        set_ch($urandom);
        start_scan(1);
        begin
            int n;
            n = 0;
            while (bus.sel != 3'd4 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) fail_now("wait_sel4");
        end
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("mid_rst_sel", 32'(bus.sel), 0);
        chk("mid_rst_snapshot", bus.snapshot, 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_idle", 32'(bus.busy), 0);
        start_scan($urandom_range(0, 4));
        wait_done();

        // Random scans, some with stray start pulses
        for (int s = 0; s < 8; s++) begin
            wait_idle();
            set_ch($urandom);
            start_scan($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            wait_done();
        end

        wait_idle();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
